// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink that checks an incrementing byte pattern, tkeep, tuser and frame length.
// Define AXIS_CHECK_BACKPRESSURE_EN to add LFSR-driven pseudo-random tready stalls.
module axis_frame_checker #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned MAX_LEN     = 1500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  enable,
  output logic                  status_valid,
  output logic [LEN_WIDTH-1:0]  status_len,
  output logic [3:0]            status_error,
  output logic [31:0]           frame_count,
  output logic [31:0]           error_count
);

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [7:0]            seed_q, seed_d;
  logic [3:0]            err_q, err_d;
  logic                  tready_q, tready_d;
  logic                  status_valid_q, status_valid_d;
  logic [LEN_WIDTH-1:0]  status_len_q, status_len_d;
  logic [3:0]            status_error_q, status_error_d;
  logic [31:0]           frame_count_q, frame_count_d;
  logic [31:0]           error_count_q, error_count_d;

  logic                  accept;
  logic [KEEP_WIDTH-1:0] keep_eff;
  logic [LEN_WIDTH:0]    beat_bytes;
  logic [LEN_WIDTH:0]    sum_wide;
  logic [LEN_WIDTH-1:0]  new_len;
  logic [LEN_WIDTH-1:0]  idx_cur;
  logic [7:0]            seed_cur;
  logic [7:0]            exp_byte;
  logic [3:0]            err_new;
  logic                  data_err;
  logic                  keep_err;
  logic                  overflow;
  logic                  unused_in;

  assign unused_in = ^{s_axis_tkeep, s_axis_tuser};
  assign accept    = s_axis_tvalid && tready_q;
  assign keep_eff  = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;

`ifdef AXIS_CHECK_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign tready_d = enable && (lfsr_q[1:0] != 2'b00);
`else
  assign tready_d = enable;
`endif

  // Per-beat checks; the first beat of a frame starts from a fresh seed, offset and error set.
  always_comb begin
    seed_cur   = (state_q == StIdle) ? frame_count_q[7:0] : seed_q;
    idx_cur    = (state_q == StIdle) ? '0 : idx_q;
    beat_bytes = '0;
    data_err   = 1'b0;
    exp_byte   = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      beat_bytes = beat_bytes + (LEN_WIDTH+1)'(keep_eff[i]);
      exp_byte   = seed_cur + idx_cur[7:0] + 8'(i);
      if (keep_eff[i] && (s_axis_tdata[8*i +: 8] != exp_byte)) data_err = 1'b1;
    end
    if (s_axis_tlast) begin
      keep_err = (keep_eff == '0) || ((keep_eff & (keep_eff + KEEP_WIDTH'(1))) != '0);
    end else begin
      keep_err = !(&keep_eff);
    end
    sum_wide = {1'b0, idx_cur} + beat_bytes;
    new_len  = sum_wide[LEN_WIDTH] ? '1 : sum_wide[LEN_WIDTH-1:0];
    overflow = sum_wide > (LEN_WIDTH+1)'(MAX_LEN);
    err_new  = (state_q == StIdle) ? 4'b0000 : err_q;
    if (state_q != StDrain) begin
      err_new[0] = err_new[0] | data_err;
      err_new[2] = err_new[2] | keep_err;
    end
    err_new[3] = err_new[3] | overflow;
    if (s_axis_tlast) err_new[1] = err_new[1] | s_axis_tuser[0];
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    seed_d         = seed_q;
    err_d          = err_q;
    status_valid_d = 1'b0;
    status_len_d   = status_len_q;
    status_error_d = status_error_q;
    frame_count_d  = frame_count_q;
    error_count_d  = error_count_q;
    if (accept) begin
      if (s_axis_tlast) begin
        state_d        = StIdle;
        idx_d          = '0;
        err_d          = '0;
        status_valid_d = 1'b1;
        status_len_d   = new_len;
        status_error_d = err_new;
        frame_count_d  = frame_count_q + 32'd1;
        if ((err_new != 4'b0000) && (error_count_q != 32'hFFFF_FFFF)) begin
          error_count_d = error_count_q + 32'd1;
        end
      end else begin
        state_d = (overflow || (state_q == StDrain)) ? StDrain : StActive;
        idx_d   = new_len;
        seed_d  = seed_cur;
        err_d   = err_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      seed_q         <= '0;
      err_q          <= '0;
      tready_q       <= 1'b0;
      status_valid_q <= 1'b0;
      status_len_q   <= '0;
      status_error_q <= '0;
      frame_count_q  <= '0;
      error_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      seed_q         <= seed_d;
      err_q          <= err_d;
      tready_q       <= tready_d;
      status_valid_q <= status_valid_d;
      status_len_q   <= status_len_d;
      status_error_q <= status_error_d;
      frame_count_q  <= frame_count_d;
      error_count_q  <= error_count_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign status_valid  = status_valid_q;
  assign status_len    = status_len_q;
  assign status_error  = status_error_q;
  assign frame_count   = frame_count_q;
  assign error_count   = error_count_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Directed bench for axis_frame_checker (32-bit data, MAX_LEN 16) with a report scoreboard.
module tb_axis_frame_checker;

  localparam int MAXL = 16;

  typedef struct packed {
    logic [15:0] len;
    logic [3:0]  err;
    logic [31:0] fc;
    logic [31:0] ec;
  } report_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic [0:0]  tuser;
  logic        enable;
  logic        tready;
  logic        status_valid;
  logic [15:0] status_len;
  logic [3:0]  status_error;
  logic [31:0] frame_count;
  logic [31:0] error_count;

  report_t exp_q[$];
  report_t obs_mem[0:255];
  int      obs_wr;
  int      obs_rd;
  int      checks;
  int      failures;
  int      stalls;
  int      fc_m;
  int      ec_m;

  axis_frame_checker #(
    .DATA_WIDTH(32),
    .MAX_LEN   (MAXL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (tdata),
    .s_axis_tkeep (tkeep),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .s_axis_tlast (tlast),
    .s_axis_tuser (tuser),
    .enable       (enable),
    .status_valid (status_valid),
    .status_len   (status_len),
    .status_error (status_error),
    .frame_count  (frame_count),
    .error_count  (error_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (status_valid) begin
      obs_mem[obs_wr[7:0]] <= {status_len, status_error, frame_count, error_count};
      obs_wr               <= obs_wr + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    int  n;
    logic ok;
    n      = 0;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tuser  = u;
    tvalid = 1'b1;
    forever begin
      @(negedge clk);
      ok = tready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 100) begin
        chk("handshake timeout", 32'(n), 32'd0);
        break;
      end
    end
    stalls += n;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic push_exp(input int len, input logic [3:0] err);
    fc_m++;
    if (err != 4'b0000) ec_m++;
    exp_q.push_back({16'(len), err, 32'(fc_m), 32'(ec_m)});
  endtask

  task automatic send_frame(input int len, input int flip, input logic user, input int pause_beat);
    int          seed;
    int          nb;
    int          b;
    logic [3:0]  err;
    logic [31:0] d;
    logic [3:0]  k;
    logic [7:0]  byt;
    logic        lst;
    seed = fc_m & 255;
    err  = 4'b0000;
    // Beats that start beyond MAX_LEN are in the drain region and not data-checked.
    if (flip >= 0 && flip < len && (flip / 4) * 4 <= MAXL) err[0] = 1'b1;
    if (user) err[1] = 1'b1;
    if (len > MAXL) err[3] = 1'b1;
    push_exp(len, err);
    b = 0;
    for (int off = 0; off < len; off += 4) begin
      nb = (len - off < 4) ? len - off : 4;
      d  = '0;
      k  = '0;
      for (int i = 0; i < nb; i++) begin
        byt = 8'(seed + off + i);
        if (off + i == flip) byt = byt ^ 8'h20;
        d[8*i +: 8] = byt;
        k[i]        = 1'b1;
      end
      lst = (off + 4 >= len);
      beat(d, k, lst, lst & user);
      if (b == pause_beat) begin
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
      end
      b++;
    end
  endtask

  task automatic check_reports(input string tag);
    int      n;
    report_t e;
    report_t o;
    n = 0;
    while ((obs_wr - obs_rd) < exp_q.size() && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " count"}, 32'(obs_wr - obs_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front();
      o = obs_mem[obs_rd[7:0]];
      obs_rd++;
      chk({tag, " len"}, 32'(o.len), 32'(e.len));
      chk({tag, " err"}, 32'(o.err), 32'(e.err));
      chk({tag, " frame_count"}, o.fc, e.fc);
      chk({tag, " error_count"}, o.ec, e.ec);
    end
    exp_q.delete();
    obs_rd = obs_wr;
  endtask

  initial begin
    logic [7:0] s;
    rst    = 1'b1;
    enable = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    tkeep  = '0;
    tlast  = 1'b0;
    tuser  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset tready", 32'(tready), 32'd0);
    chk("reset status_valid", 32'(status_valid), 32'd0);
    chk("reset status_len", 32'(status_len), 32'd0);
    chk("reset status_error", 32'(status_error), 32'd0);
    chk("reset frame_count", frame_count, 32'd0);
    chk("reset error_count", error_count, 32'd0);

    sync();
    enable = 1'b1;
    @(negedge clk);
    chk("tready lag", 32'(tready), 32'd0);
`ifndef AXIS_CHECK_BACKPRESSURE_EN
    @(negedge clk);
    chk("tready follows enable", 32'(tready), 32'd1);
`endif
    sync();

    // Single one-byte frame with seed 0.
    send_frame(1, -1, 1'b0, -1);
    check_reports("single");

    // Two of four beats, then a one-cycle reset discards the frame.
    beat(32'h04030201, 4'hF, 1'b0, 1'b0);
    beat(32'h08070605, 4'hF, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    fc_m = 0;
    ec_m = 0;
    @(negedge clk);
    chk("mid reset tready", 32'(tready), 32'd0);
    chk("mid reset status_valid", 32'(status_valid), 32'd0);
    chk("mid reset frame_count", frame_count, 32'd0);
    chk("mid reset error_count", error_count, 32'd0);
    check_reports("mid reset");

    // Back-to-back: 10 bytes with seed 0, then a frame starting 01,02,03,04.
    stalls = 0;
    send_frame(10, -1, 1'b0, -1);
    send_frame(12, -1, 1'b0, -1);
    check_reports("back2back");
`ifndef AXIS_CHECK_BACKPRESSURE_EN
    chk("back2back stalls", 32'(stalls), 32'd0);
`endif

    // Exactly MAX_LEN bytes with byte 5 corrupted: data error only.
    send_frame(16, 5, 1'b0, -1);
    check_reports("corrupt");

    // Partial mid-frame keep, then tlast with tuser set.
    s = 8'(fc_m);
    push_exp(7, 4'b0110);
    beat({8'hAA, s + 8'd2, s + 8'd1, s}, 4'b0111, 1'b0, 1'b0);
    beat({s + 8'd6, s + 8'd5, s + 8'd4, s + 8'd3}, 4'hF, 1'b1, 1'b1);
    check_reports("keep tuser");

    // Length overflow, then a clean frame must report no error.
    send_frame(20, -1, 1'b0, -1);
    send_frame(8, -1, 1'b0, -1);
    check_reports("overflow");

    // MAX_LEN+1 overflows; a corrupted byte in the drain region is ignored.
    send_frame(17, -1, 1'b0, -1);
    send_frame(24, 22, 1'b0, -1);
    send_frame(4, -1, 1'b0, -1);
    check_reports("boundary");

    // Enable dropped mid-frame keeps the frame state.
    send_frame(12, -1, 1'b0, 1);
    send_frame(16, -1, 1'b0, 0);
    check_reports("pause");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
